// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiply,
// restoring divide, one bit per cycle, followed by a one-cycle sign fix-up.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [2*WIDTH-1:0]   acc_reg;    // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]     opnd_reg;   // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]     a_orig_reg;
  logic                 div_reg;
  logic                 neg_res_reg;
  logic                 neg_rem_reg;
  logic                 dz_reg;
  logic [WIDTH-1:0]     hi_reg, lo_reg;
  logic                 done_reg;

  logic                 accept_md;
  logic                 accept_mt;
  logic                 last_iter;
  logic                 is_signed;
  logic [WIDTH-1:0]     mag_a, mag_b;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_wide;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   iter_next;

  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_raw, rem_raw;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

  assign accept_md = start && !cancel && (op[2] == 1'b0);
  assign accept_mt = start && !cancel && (op[2:1] == 2'b10);
  assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

  // Operand conditioning at issue: MULT (000) and DIV (010) are the signed ops.
  always_comb begin
    is_signed = ~op[0];
    mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;
  end

  // One iteration of either algorithm.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                {1'b0, (acc_reg[0] ? opnd_reg : {WIDTH{1'b0}})};
    div_wide  = acc_reg[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_wide >= {1'b0, opnd_reg});
    // When the trial subtract succeeds the difference is below the divisor,
    // so a WIDTH-bit modular subtract yields the exact remainder.
    div_rem   = div_ge ? (div_wide[WIDTH-1:0] - opnd_reg) : div_wide[WIDTH-1:0];
    iter_next = div_reg ? {div_rem, acc_reg[WIDTH-2:0], div_ge}
                        : {mul_sum, acc_reg[WIDTH-1:1]};
  end

  // Sign correction and divide-by-zero result selection.
  always_comb begin
    prod_fix = neg_res_reg ? -acc_reg : acc_reg;
    quo_raw  = acc_reg[WIDTH-1:0];
    rem_raw  = acc_reg[2*WIDTH-1:WIDTH];
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (div_reg) begin
      if (dz_reg) begin
        fix_lo = {WIDTH{1'b1}};
        fix_hi = a_orig_reg;
      end else begin
        fix_lo = neg_res_reg ? -quo_raw : quo_raw;
        fix_hi = neg_rem_reg ? -rem_raw : rem_raw;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: if (accept_md) state_next = RUN;
      RUN: begin
        if (cancel)         state_next = IDLE;
        else if (last_iter) state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_reg     <= '0;
      acc_reg     <= '0;
      opnd_reg    <= '0;
      a_orig_reg  <= '0;
      div_reg     <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      dz_reg      <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept_md) begin
            cnt_reg     <= '0;
            div_reg     <= op[1];
            opnd_reg    <= op[1] ? mag_b : mag_a;
            acc_reg     <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
            a_orig_reg  <= a;
            neg_res_reg <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_reg <= is_signed && a[WIDTH-1];
            dz_reg      <= (b == '0);
          end else if (accept_mt) begin
            if (op[0]) lo_reg <= a;
            else       hi_reg <= a;
          end
        end
        RUN: begin
          if (!cancel) begin
            acc_reg <= iter_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        FIX: begin
          if (!cancel) begin
            hi_reg   <= fix_hi;
            lo_reg   <= fix_lo;
            done_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi   = hi_reg;
  assign lo   = lo_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (WIDTH=32) with hand-computed results.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        cancel;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors;
  int miscompares;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one mul/div op, scramble inputs afterwards, wait (bounded) for done.
  task automatic run_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        output int lat, output int bcnt);
    start = 1'b1; op = o; a = aa; b = bb;
    step();
    start = 1'b0; op = OP_NOP; a = $urandom; b = $urandom;
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      step();
      lat++;
    end
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h latency=%0d", o, aa, bb, hi, lo, lat);
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; op = OP_NOP; a = '0; b = '0; cancel = 1'b0;
    step(); step();
    resetn = 1'b1;
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_hilo: got hi=%h lo=%h expected 0/0", hi, lo);
    end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_mult();
    int lat, bcnt;
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, lat, bcnt);
    vectors++;
    if (lat !== 33) begin
      miscompares++;
      $display("FAIL mult_latency: got %0d expected 33", lat);
    end
    vectors++;
    if (bcnt !== 33) begin
      miscompares++;
      $display("FAIL mult_busy_cycles: got %0d expected 33", bcnt);
    end
    vectors++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
      miscompares++;
      $display("FAIL mult_result: got %h_%h expected ffffffff_fffffffe", hi, lo);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mult_busy_at_done: got %b expected 0", busy);
    end
    step();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL mult_done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_multu();
    int lat, bcnt;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, lat, bcnt);
    vectors++;
    if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
      miscompares++;
      $display("FAIL multu_small: got %h_%h expected 00000001_fffffffe", hi, lo);
    end
    run_op(OP_MULTU, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
    vectors++;
    if (hi !== 32'h4000_0000 || lo !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL multu_big: got %h_%h expected 40000000_00000000", hi, lo);
    end
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFF9, lat, bcnt);
    vectors++;
    if (hi !== 32'h0 || lo !== 32'd21) begin
      miscompares++;
      $display("FAIL mult_negneg: got %h_%h expected 00000000_00000015", hi, lo);
    end
  endtask

  task automatic test_div();
    int lat, bcnt;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, lat, bcnt);
    vectors++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL div_signed: got lo=%h hi=%h expected fffffffd/ffffffff", lo, hi);
    end
    vectors++;
    if (lat !== 33) begin
      miscompares++;
      $display("FAIL div_latency: got %0d expected 33", lat);
    end
    run_op(OP_DIVU, 32'd7, 32'd2, lat, bcnt);
    vectors++;
    if (lo !== 32'd3 || hi !== 32'd1) begin
      miscompares++;
      $display("FAIL divu: got lo=%h hi=%h expected 3/1", lo, hi);
    end
    run_op(OP_DIVU, 32'd1000, 32'd37, lat, bcnt);
    vectors++;
    if (lo !== 32'd27 || hi !== 32'd1) begin
      miscompares++;
      $display("FAIL divu_1000_37: got lo=%0d hi=%0d expected 27/1", lo, hi);
    end
  endtask

  task automatic test_div_boundary();
    int lat, bcnt;
    run_op(OP_DIVU, 32'd7, 32'd0, lat, bcnt);
    vectors++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'd7) begin
      miscompares++;
      $display("FAIL divu_by_zero: got lo=%h hi=%h expected ffffffff/00000007", lo, hi);
    end
    vectors++;
    if (lat !== 33) begin
      miscompares++;
      $display("FAIL div0_latency: got %0d expected 33", lat);
    end
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, lat, bcnt);
    vectors++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF9) begin
      miscompares++;
      $display("FAIL div_by_zero_neg: got lo=%h hi=%h expected ffffffff/fffffff9", lo, hi);
    end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    vectors++;
    if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
      miscompares++;
      $display("FAIL div_overflow: got lo=%h hi=%h expected 80000000/00000000", lo, hi);
    end
  endtask

  task automatic test_mthi_mtlo();
    logic saw_busy, saw_done;
    logic [31:0] lo_before;
    lo_before = lo;
    saw_busy = 1'b0; saw_done = 1'b0;
    start = 1'b1; op = OP_MTHI; a = 32'h1234_5678;
    step();
    start = 1'b0; op = OP_NOP; a = 32'h0;
    saw_busy |= busy; saw_done |= done;
    $display("MTHI a=12345678 -> hi=%h lo=%h", hi, lo);
    vectors++;
    if (hi !== 32'h1234_5678 || lo !== lo_before) begin
      miscompares++;
      $display("FAIL mthi: got hi=%h lo=%h expected 12345678/%h", hi, lo, lo_before);
    end
    start = 1'b1; op = OP_MTLO; a = 32'h9ABC_DEF0;
    step();
    start = 1'b0; op = OP_NOP; a = 32'h0;
    saw_busy |= busy; saw_done |= done;
    step();
    saw_busy |= busy; saw_done |= done;
    $display("MTLO a=9abcdef0 -> hi=%h lo=%h", hi, lo);
    vectors++;
    if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL mtlo: got hi=%h lo=%h expected 12345678/9abcdef0", hi, lo);
    end
    vectors++;
    if (saw_busy !== 1'b0 || saw_done !== 1'b0) begin
      miscompares++;
      $display("FAIL mt_flags: got busy_seen=%b done_seen=%b expected 0/0", saw_busy, saw_done);
    end
    start = 1'b1; op = OP_NOP; a = 32'hDEAD_BEEF; b = 32'h1;
    step();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
      miscompares++;
      $display("FAIL nop: got busy=%b hi=%h lo=%h expected 0/12345678/9abcdef0", busy, hi, lo);
    end
  endtask

  task automatic test_start_held();
    int lat;
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd5;
    step();
    lat = 0;
    while (!done && lat < 100) begin
      op = (lat % 2 == 0) ? OP_MTHI : OP_DIVU;
      a = 32'hCAFE_0000 + lat; b = 32'd9;
      step();
      lat++;
    end
    start = 1'b0; op = OP_NOP;
    $display("MULT held-start a=3 b=5 -> hi=%h lo=%h latency=%0d", hi, lo, lat);
    vectors++;
    if (hi !== 32'h0 || lo !== 32'd15) begin
      miscompares++;
      $display("FAIL start_held_result: got hi=%h lo=%h expected 0/15", hi, lo);
    end
    vectors++;
    if (lat !== 33) begin
      miscompares++;
      $display("FAIL start_held_latency: got %0d expected 33", lat);
    end
    step();
  endtask

  task automatic test_cancel();
    int dcount;
    start = 1'b1; op = OP_MTHI; a = 32'hAAAA_AAAA; step();
    op = OP_MTLO; a = 32'h5555_5555; step();
    op = OP_DIV; a = 32'd100; b = 32'd7; step();
    start = 1'b0; op = OP_NOP;
    for (int i = 0; i < 9; i++) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    $display("DIV 100/7 cancelled -> busy=%b hi=%h lo=%h", busy, hi, lo);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL cancel_busy: got %b expected 0", busy);
    end
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcount++;
      step();
    end
    vectors++;
    if (dcount !== 0) begin
      miscompares++;
      $display("FAIL cancel_done: got %0d pulses expected 0", dcount);
    end
    vectors++;
    if (hi !== 32'hAAAA_AAAA || lo !== 32'h5555_5555) begin
      miscompares++;
      $display("FAIL cancel_hilo: got hi=%h lo=%h expected aaaaaaaa/55555555", hi, lo);
    end
    start = 1'b1; cancel = 1'b1; op = OP_MTHI; a = 32'h0BAD_0BAD;
    step();
    start = 1'b0; cancel = 1'b0; op = OP_NOP;
    vectors++;
    if (hi !== 32'hAAAA_AAAA || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL cancel_idle_mthi: got hi=%h busy=%b expected aaaaaaaa/0", hi, busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, dcount;
    start = 1'b1; op = OP_MULT; a = 32'd11; b = 32'd13;
    step();
    start = 1'b0; op = OP_NOP;
    for (int i = 0; i < 19; i++) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    $display("MULT 11*13 reset mid-op -> busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    vectors++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got hi=%h lo=%h busy=%b done=%b expected 0/0/0/0", hi, lo, busy, done);
    end
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) dcount++;
      step();
    end
    vectors++;
    if (dcount !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", dcount);
    end
    run_op(OP_MULTU, 32'd5, 32'd7, lat, bcnt);
    vectors++;
    if (hi !== 32'h0 || lo !== 32'd35) begin
      miscompares++;
      $display("FAIL after_reset_multu: got hi=%h lo=%h expected 0/35", hi, lo);
    end
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, lat, bcnt);
    vectors++;
    if (lo !== 32'h0000_FFFF || hi !== 32'h0000_FFFF) begin
      miscompares++;
      $display("FAIL back_to_back_divu: got lo=%h hi=%h expected 0000ffff/0000ffff", lo, hi);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_boundary();
    test_mthi_mtlo();
    test_start_held();
    test_cancel();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
